// File: rtl/fifo_word_packer_pkg.sv
// Shared types and constants for the byte-to-word packer.
package fifo_pack_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    FILL,
    OUT
  } state_e;

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed-word output port of the packer, bundled as one interface.
interface fifo_word_packer_if
  import fifo_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4
);

  logic                             fifo_rreq;
  logic [BYTE_W-1:0]                fifo_rdata;
  logic                             fifo_isempty;
  logic                             fifo_rready;
  logic                             flush;
  logic [BYTE_W*BYTES_PER_WORD-1:0] word_data;
  logic [BYTES_PER_WORD-1:0]        word_keep;
  logic                             word_valid;
  logic                             word_ready;

  // master is the packer itself; slave is the FIFO/sink environment around it
  modport master (
    output fifo_rreq, word_data, word_keep, word_valid,
    input  fifo_rdata, fifo_isempty, fifo_rready, flush, word_ready
  );

  modport slave (
    input  fifo_rreq, word_data, word_keep, word_valid,
    output fifo_rdata, fifo_isempty, fifo_rready, flush, word_ready
  );

endinterface

// File: rtl/fifo_word_packer_idle_timer.sv
// Idle-cycle counter that saturates at TIMEOUT-1 and flags expiry; TIMEOUT=0 never expires.
module fifo_pack_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int CW    = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] idle_ctr_q, idle_ctr_d;

  always_comb begin
    idle_ctr_d = idle_ctr_q;
    if (clear_i) begin
      idle_ctr_d = '0;
    end else if (enable_i && (idle_ctr_q != CW'(LIMIT))) begin
      idle_ctr_d = idle_ctr_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_ctr_q <= '0;
    end else begin
      idle_ctr_q <= idle_ctr_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (idle_ctr_q == CW'(LIMIT));

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from a 1-cycle-latency FIFO and packs them little-endian into words,
// emitting partial words on flush or idle timeout with per-lane keep flags.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 16
) (
  input logic               clk,
  input logic               resetn,
  fifo_word_packer_if.master bus
);

  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_landed;
  logic                      pend_q;
  logic [WORD_W-1:0]         data_q, data_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
  logic                      valid_q;

  logic fire;
  logic has_bytes;
  logic partial_emit;
  logic leave_fill;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  // A read is only requested when the in-flight byte still leaves room in the word
  assign has_bytes  = (cnt_q != '0);
  assign fire       = (state_q == FILL) && !bus.fifo_isempty && bus.fifo_rready &&
                      ((int'(cnt_q) + int'(pend_q)) < BYTES_PER_WORD);
  assign cnt_landed = cnt_q + CNT_W'(pend_q);

  assign partial_emit = (state_q == FILL) && has_bytes && !pend_q && !fire &&
                        (bus.flush || timer_expired);

  assign leave_fill   = (state_q == FILL) && (state_d == OUT);
  assign timer_clear  = fire || (state_q != FILL) || !has_bytes || leave_fill;
  assign timer_enable = (state_q == FILL) && has_bytes && !fire;

  fifo_pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    case (state_q)
      FILL: begin
        if (pend_q) begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              data_d[i*BYTE_W +: BYTE_W] = bus.fifo_rdata;
            end
          end
        end
        cnt_d = cnt_landed;
        if (cnt_landed == CNT_W'(BYTES_PER_WORD)) begin
          state_d = OUT;
          keep_d  = '1;
        end else if (partial_emit) begin
          state_d = OUT;
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            keep_d[i] = (CNT_W'(i) < cnt_q);
          end
        end
      end
      OUT: begin
        if (bus.word_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          data_d  = '0;
          keep_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // A byte in flight across reset is dropped because pend_q restarts at zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= fire;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= (state_d == OUT);
    end
  end

  assign bus.fifo_rreq  = fire;
  assign bus.word_data  = data_q;
  assign bus.word_keep  = keep_q;
  assign bus.word_valid = valid_q;

endmodule
